// File: rtl/uart_tx.sv
// uart_tx: UART-style serial transmitter.
//   Latches DataIn on a rising edge of Pload (accepted only while idle) and sends
//   one frame on DataOut: start bit, 8 data bits LSB first, optional parity bit,
//   stop bit. Each bit lasts CLKS_PER_BIT system clocks.
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous active-low reset
//   DataOut      out  serial line, idles high (registered)
//   DataIn[7:0]  in   byte to send, sampled only on the accepted load edge
//   Pload        in   load request, rising-edge sensitive
//   Enable       in   1 = freeze the frame in progress, 0 = run (no effect while idle)
//   CharReceived out  one-clock pulse at the end of the stop bit (registered)
// Parameters:
//   CLKS_PER_BIT 2..65535 clocks per serial bit
//   PARITY       0 = none, 1 = even, 2 = odd

// Baud-tick generator: counts 0..CLKS_PER_BIT-1 while run is high, ticks on the
// last count. Holding run low freezes the count, so a stalled frame resumes
// with its bit timing intact.
module uart_tx_baud #(
   parameter int CLKS_PER_BIT = 2604
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clear,
   input  logic run,
   output logic tick
);
   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
   end

   assign tick = run && (cnt == LAST);
endmodule

// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | line high, waiting for a Pload rising edge
// ST_START   | start bit (line low)
// ST_DATA    | data bits, LSB first, bit_idx 0..7
// ST_PARITY  | parity bit (only when PARITY != 0)
// ST_STOP    | stop bit (line high); CharReceived on its last clock
module uart_tx #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int PARITY       = 0
) (
   input  logic       Clock,
   input  logic       Reset,
   output logic       DataOut,
   input  logic [7:0] DataIn,
   input  logic       Pload,
   input  logic       Enable,
   output logic       CharReceived
);
   localparam logic HAS_PARITY = (PARITY != 0);
   localparam logic ODD_PARITY = (PARITY == 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t     state, state_d;
   logic [7:0] shift_reg, shift_d;
   logic [2:0] bit_idx, idx_d;
   logic       par_bit, par_d;
   logic       pload_q;
   logic       out_d;
   logic       cr_d;
   logic       load_edge;
   logic       run;
   logic       tick;

   assign load_edge = Pload & ~pload_q;
   assign run       = (state != ST_IDLE) & ~Enable;

   uart_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk_sys (Clock),
      .rst_b   (Reset),
      .clear   (state == ST_IDLE),
      .run     (run),
      .tick    (tick)
   );

   // pload_q resets high so a Pload held through reset is not seen as an edge.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state        <= ST_IDLE;
         shift_reg    <= '0;
         bit_idx      <= '0;
         par_bit      <= 1'b0;
         pload_q      <= 1'b1;
         DataOut      <= 1'b1;
         CharReceived <= 1'b0;
      end else begin
         state        <= state_d;
         shift_reg    <= shift_d;
         bit_idx      <= idx_d;
         par_bit      <= par_d;
         pload_q      <= Pload;
         DataOut      <= out_d;
         CharReceived <= cr_d;
      end
   end

   // DataOut is registered, so each transition drives the level of the bit
   // being entered; parity is captured at load because the shifter is consumed.
   always_comb begin
      state_d = state;
      shift_d = shift_reg;
      idx_d   = bit_idx;
      par_d   = par_bit;
      out_d   = DataOut;
      cr_d    = 1'b0;
      case (state)
         ST_IDLE: begin
            out_d = 1'b1;
            idx_d = 3'd0;
            if (load_edge) begin
               shift_d = DataIn;
               par_d   = (^DataIn) ^ ODD_PARITY;
               out_d   = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               idx_d   = 3'd0;
               out_d   = shift_reg[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_reg[7:1]};
               idx_d   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  if (HAS_PARITY) begin
                     state_d = ST_PARITY;
                     out_d   = par_bit;
                  end else begin
                     state_d = ST_STOP;
                     out_d   = 1'b1;
                  end
               end else begin
                  out_d = shift_reg[1];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               out_d   = 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               state_d = ST_IDLE;
               out_d   = 1'b1;
               cr_d    = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            out_d   = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity, even, odd) share one stimulus
// stream. A time-based frame model checks every output on every cycle; frame
// tasks add literal checks on line levels and CharReceived timing.
module tb_uart_tx;
   localparam int N = 16;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] DataIn = 8'h00;
   logic       Pload = 1'b1;
   logic       Enable = 1'b0;
   logic [2:0] dout;
   logic [2:0] crv;

   int n_cmp  = 0;
   int n_fail = 0;
   bit done   = 1'b0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(N), .PARITY(0)) dut0 (
      .Clock(clk), .Reset(Reset), .DataOut(dout[0]), .DataIn(DataIn),
      .Pload(Pload), .Enable(Enable), .CharReceived(crv[0]));
   uart_tx #(.CLKS_PER_BIT(N), .PARITY(1)) dut1 (
      .Clock(clk), .Reset(Reset), .DataOut(dout[1]), .DataIn(DataIn),
      .Pload(Pload), .Enable(Enable), .CharReceived(crv[1]));
   uart_tx #(.CLKS_PER_BIT(N), .PARITY(2)) dut2 (
      .Clock(clk), .Reset(Reset), .DataOut(dout[2]), .DataIn(DataIn),
      .Pload(Pload), .Enable(Enable), .CharReceived(crv[2]));

   task automatic check(input string name, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Model: a frame is a list of bit levels; the line shows bits[t / N] where t
   // counts un-stalled clocks since the accepted load edge.
   int         par_mode [3] = '{0, 1, 2};
   logic       m_busy   [3] = '{1'b0, 1'b0, 1'b0};
   int         m_t      [3] = '{0, 0, 0};
   int         m_nb     [3] = '{10, 10, 10};
   logic [10:0] m_bits  [3];
   logic       m_pq     [3] = '{1'b1, 1'b1, 1'b1};
   logic       exp_out  [3] = '{1'b1, 1'b1, 1'b1};
   logic       exp_cr   [3] = '{1'b0, 1'b0, 1'b0};

   always @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int d = 0; d < 3; d++) begin
            m_busy[d] = 1'b0; m_pq[d] = 1'b1; exp_out[d] = 1'b1; exp_cr[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            logic ld;
            ld = Pload && !m_pq[d];
            m_pq[d] = Pload;
            exp_cr[d] = 1'b0;
            if (!m_busy[d]) begin
               if (ld) begin
                  m_bits[d] = 11'h7FF;
                  m_bits[d][0] = 1'b0;
                  for (int i = 0; i < 8; i++) m_bits[d][i+1] = DataIn[i];
                  if (par_mode[d] == 0) m_nb[d] = 10;
                  else begin
                     m_nb[d] = 11;
                     m_bits[d][9] = (^DataIn) ^ (par_mode[d] == 2);
                  end
                  m_busy[d] = 1'b1; m_t[d] = 0; exp_out[d] = 1'b0;
               end
            end else if (!Enable) begin
               m_t[d]++;
               if (m_t[d] == m_nb[d] * N) begin
                  m_busy[d] = 1'b0; exp_cr[d] = 1'b1; exp_out[d] = 1'b1;
               end else begin
                  exp_out[d] = m_bits[d][m_t[d] / N];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!done) begin
         for (int d = 0; d < 3; d++) begin
            check($sformatf("model line dut%0d", d), dout[d], exp_out[d]);
            check($sformatf("model char dut%0d", d), crv[d], exp_cr[d]);
         end
      end
   end

   // Drives one load edge, runs ncyc clocks, samples each bit at mid-bit and
   // records the CharReceived offset (in clocks after the load edge).
   task automatic run_frame(input logic [7:0] b, input int stall, input bit poke,
                            input int ncyc,
                            output logic [9:0] l0, output logic [10:0] l1,
                            output logic [10:0] l2, output int cr0, output int cr1,
                            output int cr2, output int extra);
      @(negedge clk);
      Pload = 1'b0; DataIn = b;
      @(negedge clk);
      check("idle gap line", dout, 3'b111);
      Pload = 1'b1;
      l0 = '0; l1 = '0; l2 = '0;
      cr0 = -1; cr1 = -1; cr2 = -1; extra = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         for (int bt = 0; bt < 11; bt++) begin
            if (c == bt * N + N / 2 + ((bt >= 5) ? stall : 0)) begin
               if (bt < 10) l0[bt] = dout[0];
               l1[bt] = dout[1];
               l2[bt] = dout[2];
            end
         end
         if (crv[0]) begin if (cr0 < 0) cr0 = c - 1; else extra++; end
         if (crv[1]) begin if (cr1 < 0) cr1 = c - 1; else extra++; end
         if (crv[2]) begin if (cr2 < 0) cr2 = c - 1; else extra++; end
         if (c == 2) DataIn = 8'($urandom);
         if (stall > 0 && c == 4 * N + 4) Enable = 1'b1;
         if (stall > 0 && c == 4 * N + 4 + stall) Enable = 1'b0;
         if (poke && c == 30) Pload = 1'b0;
         if (poke && c == 32) Pload = 1'b1;
         if (poke && c == 40) DataIn = ~b;
      end
   endtask

   task automatic frame_checks(input logic [7:0] b, input int stall,
                               input logic [9:0] l0, input logic [10:0] l1,
                               input logic [10:0] l2, input int cr0, input int cr1,
                               input int cr2, input int extra);
      check("frame line p0", l0, {1'b1, b, 1'b0});
      check("frame line even", l1, {1'b1, ^b, b, 1'b0});
      check("frame line odd", l2, {1'b1, ~^b, b, 1'b0});
      check("char offset p0", cr0, 10 * N + stall);
      check("char offset even", cr1, 11 * N + stall);
      check("char offset odd", cr2, 11 * N + stall);
      check("extra frames", extra, 0);
   endtask

   logic [9:0]  l0;
   logic [10:0] l1, l2;
   int cr0, cr1, cr2, extra;
   logic [7:0] seq [5] = '{8'hEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

   initial begin
      int cnt;
      // Reset held with Pload high and DataIn moving; no frame on release.
      #1 Reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         DataIn = 8'($urandom);
         check("reset line", dout, 3'b111);
         check("reset char", crv, 3'b000);
      end
      #2 Reset = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (crv != 3'b000) cnt++;
      end
      check("no frame after reset", cnt, 0);
      check("line after reset", dout, 3'b111);

      // Basic 0xCE frame with Pload held high for 2500 clocks.
      run_frame(8'hCE, 0, 1'b0, 2500, l0, l1, l2, cr0, cr1, cr2, extra);
      frame_checks(8'hCE, 0, l0, l1, l2, cr0, cr1, cr2, extra);
      check("CE literal p0", l0, 10'b1110011100);
      check("CE literal even", l1, 11'b11110011100);
      check("CE literal odd", l2, 11'b10110011100);
      check("CE char at 160", cr0, 160);
      check("CE parity len 176", cr1, 176);

      // Successive bytes, each after the previous CharReceived.
      for (int i = 0; i < 5; i++) begin
         run_frame(seq[i], 0, 1'b0, 300, l0, l1, l2, cr0, cr1, cr2, extra);
         frame_checks(seq[i], 0, l0, l1, l2, cr0, cr1, cr2, extra);
         if (i == 0) check("EF literal p0", l0, 10'b1111011110);
      end

      // Busy load pulse and DataIn change mid-frame.
      run_frame(8'h3C, 0, 1'b1, 400, l0, l1, l2, cr0, cr1, cr2, extra);
      frame_checks(8'h3C, 0, l0, l1, l2, cr0, cr1, cr2, extra);

      // 50-clock Enable stall during data bit 3.
      run_frame(8'hA5, 50, 1'b0, 400, l0, l1, l2, cr0, cr1, cr2, extra);
      frame_checks(8'hA5, 50, l0, l1, l2, cr0, cr1, cr2, extra);
      check("stall char p0", cr0, 210);

      // Abort with reset during data bit 1 (a 0 on the line for 0x55).
      @(negedge clk); Pload = 1'b0; DataIn = 8'h55;
      @(negedge clk); Pload = 1'b1;
      repeat (40) @(negedge clk);
      check("abort pre line", dout, 3'b000);
      #2 Reset = 1'b0;
      #1;
      check("abort async line", dout, 3'b111);
      check("abort char", crv, 3'b000);
      repeat (3) @(negedge clk);
      Pload = 1'b0;
      #2 Reset = 1'b1;
      cnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (crv != 3'b000) cnt++;
      end
      check("no char after abort", cnt, 0);

      // Random loads, data and stalls against the model.
      repeat (3000) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) Pload = ~Pload;
         DataIn = 8'($urandom);
         Enable = ($urandom_range(0, 19) == 0);
      end
      @(negedge clk);
      Enable = 1'b0;
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
